// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and command type shared by the ALU and its command front end
package alu_pkg;
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHR = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_GT  = 3'd7;
   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
   } alu_cmd_t;
endpackage

// File: rtl/alu_cmd_issue_if.sv
// alu_cmd_issue_if: command, ALU and result handshake bundle of alu_cmd_issue
interface alu_cmd_issue_if #(parameter int DEPTH = 4);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [3:0]             cmd_a;
   logic [3:0]             cmd_b;
   logic [2:0]             cmd_op;
   logic [3:0]             alu_a;
   logic [3:0]             alu_b;
   logic [2:0]             alu_op;
   logic [7:0]             alu_result;
   logic                   res_valid;
   logic                   res_ready;
   logic [7:0]             res_data;
   logic [2:0]             res_op;
   logic [$clog2(DEPTH):0] count;
   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, res_ready,
      input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_op, count
   );
   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, res_ready,
      output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_op, count
   );
endinterface

// File: rtl/alu_4bit.sv
// alu_4bit: registered 4-bit ALU with 8-bit zero-extended result
module alu_4bit
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [2:0] op,
   output logic [7:0] result
);
   logic [7:0] a8, b8, f;
   assign a8 = {4'h0, A};
   assign b8 = {4'h0, B};
   always_comb
      f = op == OP_ADD ? a8 + b8 :
          op == OP_SUB ? a8 - b8 :
          op == OP_AND ? a8 & b8 :
          op == OP_OR  ? a8 | b8 :
          op == OP_XOR ? a8 ^ b8 :
          op == OP_SHR ? a8 >> B :
          op == OP_SHL ? a8 << B : {7'd0, A > B};
   always_ff @(posedge clk)
      result <= rst ? 8'd0 : f;
endmodule

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO; head reads as zero when empty
module alu_cmd_fifo
   import alu_pkg::*;
#(parameter int DEPTH = 4)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  alu_cmd_t               din,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output alu_cmd_t               head
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   alu_cmd_t mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic wr, rd;
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
   assign wr    = push && !full;
   assign rd    = pop && !empty;
   assign head  = empty ? '0 : mem[rp];
   always_ff @(posedge clk)
      if (wr) mem[wp] <= din;
   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= wr ? wp + AW'(1) : wp;
         rp    <= rd ? rp + AW'(1) : rp;
         count <= count + CW'(wr) - CW'(rd);
      end
   end
endmodule

// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: buffers ALU commands, issues one at a time, captures result with its opcode
module alu_cmd_issue
   import alu_pkg::*;
#(parameter int DEPTH = 4)
(
   input logic           clk,
   input logic           rst,
   alu_cmd_issue_if.slave bus
);
   alu_cmd_t   head, din;
   logic       full, empty, issue, inflight;
   logic [2:0] inflight_op;
   assign din = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
   alu_cmd_fifo #(.DEPTH(DEPTH)) fifo (
      .clk(clk), .rst(rst), .push(bus.cmd_valid), .din(din), .pop(issue),
      .full(full), .empty(empty), .count(bus.count), .head(head)
   );
   assign bus.cmd_ready = !full;
   assign bus.alu_a     = head.a;
   assign bus.alu_b     = head.b;
   assign bus.alu_op    = head.op;
   // one command in flight at most, and never over an unconsumed result
   assign issue = !empty && !inflight && (!bus.res_valid || bus.res_ready);
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight      <= 1'b0;
         inflight_op   <= 3'd0;
         bus.res_valid <= 1'b0;
         bus.res_data  <= 8'd0;
         bus.res_op    <= 3'd0;
      end else begin
         inflight <= issue;
         if (issue) inflight_op <= head.op;
         if (inflight) begin
            bus.res_valid <= 1'b1;
            bus.res_data  <= bus.alu_result;
            bus.res_op    <= inflight_op;
         end else if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb_alu_cmd_issue: directed vectors against alu_cmd_issue driving alu_4bit
module tb_alu_cmd_issue;
   import alu_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   alu_cmd_issue_if #(.DEPTH(4)) bus ();
   alu_cmd_issue #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   alu_4bit alu (.clk(clk), .rst(rst), .A(bus.alu_a), .B(bus.alu_b), .op(bus.alu_op), .result(bus.alu_result));
   int n_cmp = 0;
   int n_bad = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      bus.cmd_valid = v;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_op    = op;
   endtask
   task automatic run_one(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic [7:0] exp);
      int n;
      drive(1'b1, a, b, op);
      @(negedge clk);
      drive(1'b0, 4'd0, 4'd0, 3'd0);
      n = 0;
      while (!bus.res_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, n, 2);
      chk({tag, "_data"}, bus.res_data, exp);
      chk({tag, "_op"}, bus.res_op, op);
      @(negedge clk);
      chk({tag, "_popped"}, bus.res_valid, 0);
   endtask
   task automatic collect(input string tag, input logic [10:0] exp [$]);
      int k;
      k = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.res_valid) begin
            if (k < exp.size()) chk(tag, {bus.res_data, bus.res_op}, exp[k]);
            k++;
         end
      end
      chk({tag, "_n"}, k, exp.size());
   endtask
   logic [10:0] q [$];
   logic [10:0] scmd [6] = '{{4'h1, 4'h2, OP_ADD}, {4'hA, 4'h5, OP_OR}, {4'hC, 4'h6, OP_AND},
                             {4'hF, 4'h3, OP_XOR}, {4'h0, 4'h1, OP_SUB}, {4'h1, 4'h7, OP_SHL}};
   logic [10:0] sexp [6] = '{{8'h03, OP_ADD}, {8'h0F, OP_OR}, {8'h04, OP_AND},
                             {8'h0C, OP_XOR}, {8'hFF, OP_SUB}, {8'h80, OP_SHL}};
   logic [10:0] fcmd [6] = '{{4'h1, 4'h1, OP_ADD}, {4'hF, 4'h3, OP_SHL}, {4'h8, 4'h2, OP_SHR},
                             {4'h9, 4'h4, OP_GT}, {4'h4, 4'h9, OP_GT}, {4'h5, 4'h3, OP_XOR}};
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int p, r, last, maxc;
      logic acc, seen;
      bus.res_ready = 1'b1;
      drive(1'b1, 4'h3, 4'h5, OP_ADD);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready", bus.cmd_ready, 1);
      chk("rst_count", bus.count, 0);
      chk("rst_valid", bus.res_valid, 0);
      chk("rst_data", bus.res_data, 0);
      chk("rst_op", bus.res_op, 0);
      chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_op}, 0);
      rst = 1'b0;
      drive(1'b0, 4'd0, 4'd0, 3'd0);
      @(negedge clk);
      chk("rst_nopush", bus.count, 0);
      run_one("add", 4'h3, 4'h5, OP_ADD, 8'h08);
      run_one("sub", 4'h2, 4'h5, OP_SUB, 8'hFD);
      // fill under backpressure: sixth push must be refused
      bus.res_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, fcmd[i][10:7], fcmd[i][6:3], fcmd[i][2:0]);
         @(negedge clk);
      end
      drive(1'b0, 4'd0, 4'd0, 3'd0);
      chk("fill_count", bus.count, 4);
      chk("fill_ready", bus.cmd_ready, 0);
      chk("fill_hold", {bus.res_valid, bus.res_data, bus.res_op}, {1'b1, 8'h02, OP_ADD});
      repeat (3) @(negedge clk);
      chk("fill_stall", {bus.count, bus.res_valid}, {3'd4, 1'b1});
      bus.res_ready = 1'b1;
      q.delete();
      q.push_back({8'h78, OP_SHL});
      q.push_back({8'h02, OP_SHR});
      q.push_back({8'h01, OP_GT});
      q.push_back({8'h00, OP_GT});
      collect("drain", q);
      chk("drain_count", bus.count, 0);
      p = 0; r = 0; last = 0; maxc = 0;
      for (int cyc = 0; cyc < 40 && r < 6; cyc++) begin
         if (p < 6) drive(1'b1, scmd[p][10:7], scmd[p][6:3], scmd[p][2:0]);
         else drive(1'b0, 4'd0, 4'd0, 3'd0);
         acc = bus.cmd_valid && bus.cmd_ready;
         if (int'(bus.count) > maxc) maxc = int'(bus.count);
         if (bus.res_valid) begin
            chk("stream_data", {bus.res_data, bus.res_op}, sexp[r]);
            if (r > 0) chk("stream_gap", cyc - last, 2);
            last = cyc;
            r++;
         end
         @(negedge clk);
         if (acc) p++;
      end
      drive(1'b0, 4'd0, 4'd0, 3'd0);
      chk("stream_all", r, 6);
      chk("stream_bound", maxc <= 4, 1);
      // push and issue pop in the same edge at count 2
      bus.res_ready = 1'b0;
      for (int i = 2; i < 5; i++) begin
         drive(1'b1, 4'(i), 4'(i), OP_ADD);
         @(negedge clk);
      end
      chk("sim_pre", {bus.count, bus.res_valid, bus.res_data}, {3'd2, 1'b1, 8'h04});
      bus.res_ready = 1'b1;
      drive(1'b1, 4'h5, 4'h5, OP_ADD);
      @(negedge clk);
      drive(1'b0, 4'd0, 4'd0, 3'd0);
      chk("sim_count", bus.count, 2);
      q.delete();
      q.push_back({8'h06, OP_ADD});
      q.push_back({8'h08, OP_ADD});
      q.push_back({8'h0A, OP_ADD});
      collect("sim_order", q);
      drive(1'b1, 4'h7, 4'h7, OP_ADD);
      @(negedge clk);
      drive(1'b1, 4'h1, 4'h2, OP_ADD);
      @(negedge clk);
      drive(1'b0, 4'd0, 4'd0, 3'd0);
      chk("mr_pre_count", bus.count, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mr_state", {bus.res_valid, bus.count, bus.cmd_ready}, {1'b0, 3'd0, 1'b1});
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | bus.res_valid;
      end
      chk("mr_no_result", seen, 0);
      run_one("mr_next", 4'h6, 4'h7, OP_ADD, 8'h0D);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
